frame_mem_arbiter: RTL and testbench

//  Shares the single-port frame/background SRAM between pipeline stages: frame manager (req 0),

---
 rtl/motion_pkg.sv | 7 +
 rtl/rr_pick.sv | 18 +
 rtl/frame_mem_arbiter.sv | 105 ++++++++++
 tb/tb_frame_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// motion_pkg: shared arbiter state type and requester index constants
package motion_pkg;
    typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} arb_state_t;
    localparam int REQ_FRAME_MGR = 0;
    localparam int REQ_SIGMA     = 1;
    localparam int REQ_MEM_MGR   = 2;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational cyclic priority picker, first set request at or after ptr
module rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [1:0]   winner,
    output logic         found
);
    logic [2*N-1:0] dbl;
    assign dbl   = {req, req} >> ptr;
    assign found = |req;
    always_comb begin
        winner = '0;
        for (int k = N - 1; k >= 0; k--)
            if (dbl[k]) winner = 2'((int'(ptr) + k) % N);
    end
endmodule

// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: round-robin burst arbiter sharing one single-port SRAM between stages.
// Define FRAME_MEM_ARB_PRIO_EN to give requester 0 fixed priority with preemption.
module frame_mem_arbiter
    import motion_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [1:0]                grant_id,
    output logic                      busy
);
    localparam int CW = $clog2(MAX_BURST);
    localparam logic [1:0] LAST_ID = 2'(NUM_REQ - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    arb_state_t state;
    logic [1:0] owner, owner_d1, rr_ptr, nxt_ptr, rr_win, winner, cur;
    logic [CW-1:0] beat_cnt, cnt_eff;
    logic [NUM_REQ-1:0] pick_req;
    logic rr_found, found, preempt, active, acc, fin, rd_d1;
    logic [ADDR_W-1:0] addr_a [NUM_REQ];
    logic [DATA_W-1:0] wdata_a [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
    end

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req    (pick_req),
        .ptr    (rr_ptr),
        .winner (rr_win),
        .found  (rr_found)
    );

`ifdef FRAME_MEM_ARB_PRIO_EN
    assign pick_req = req_valid & ~(NUM_REQ'(1));
    assign found    = rr_found | req_valid[REQ_FRAME_MGR];
    assign winner   = req_valid[REQ_FRAME_MGR] ? 2'(REQ_FRAME_MGR) : rr_win;
    assign preempt  = state == BURST && owner != 2'(REQ_FRAME_MGR) && req_valid[REQ_FRAME_MGR];
    assign nxt_ptr  = winner == 2'(REQ_FRAME_MGR) ? rr_ptr : winner == LAST_ID ? 2'd1 : winner + 2'd1;
`else
    assign pick_req = req_valid;
    assign found    = rr_found;
    assign winner   = rr_win;
    assign preempt  = 1'b0;
    assign nxt_ptr  = winner == LAST_ID ? 2'd0 : winner + 2'd1;
`endif

    // outside a burst the winner is granted and its beat accepted in the same cycle
    assign cur     = state == BURST ? owner : winner;
    assign cnt_eff = state == BURST ? beat_cnt : '0;
    assign active  = !rst && (state == BURST || found);
    assign acc     = active && req_valid[cur];
    assign fin     = (acc && (req_last[cur] || cnt_eff == CNT_MAX)) || preempt;

    assign req_ready = acc ? NUM_REQ'(1) << cur : '0;
    assign mem_en    = acc;
    assign mem_we    = acc && req_we[cur];
    assign mem_addr  = acc ? addr_a[cur] : '0;
    assign mem_wdata = acc ? wdata_a[cur] : '0;
    assign rsp_valid = rd_d1 ? NUM_REQ'(1) << owner_d1 : '0;
    assign rsp_rdata = rd_d1 ? mem_rdata : '0;
    assign grant_id  = active ? cur : 2'd0;
    assign busy      = active;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            owner_d1 <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            rd_d1    <= 1'b0;
        end else begin
            rd_d1    <= acc && !req_we[cur];
            owner_d1 <= cur;
            if (state == IDLE && found) rr_ptr <= nxt_ptr;
            if (acc) owner <= cur;
            if (fin) begin
                state    <= IDLE;
                beat_cnt <= '0;
            end else if (acc) begin
                state    <= BURST;
                beat_cnt <= cnt_eff + CW'(1);
            end
        end
endmodule

// File: tb/tb_frame_mem_arbiter.sv
// tb_frame_mem_arbiter: scoreboard bench for frame_mem_arbiter with a behavioural SRAM
module tb_frame_mem_arbiter;
    import motion_pkg::*;
    localparam int N = 3, AW = 19, DW = 16;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk, rst;
    logic [N-1:0] req_valid, req_we, req_last, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0] rsp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic mem_en, mem_we, busy;
    logic [1:0] grant_id;

    beat_t bq [N][$];
    logic [DW-1:0] exp_q [N][$];
    logic [DW-1:0] mdl [int];
    logic [DW-1:0] sram [int];
    int glog[$], en_cyc[$], rsp_cyc[$], e[$];
    int n_chk, n_fail, cyc;
    logic s_busy;
    logic [N-1:0] acc;

    frame_mem_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_last(req_last),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] f(logic [AW-1:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction

    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) sram[int'(mem_addr)] = mem_wdata;
            else mem_rdata <= sram.exists(int'(mem_addr)) ? sram[int'(mem_addr)] : f(mem_addr);
        end

    task automatic check(string tag, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    task automatic drive();
        beat_t h;
        for (int i = 0; i < N; i++) begin
            h = bq[i].size() > 0 ? bq[i][0] : '0;
            req_valid[i] = bq[i].size() > 0;
            req_we[i] = h.we;
            req_last[i] = h.last;
            req_addr[i*AW +: AW] = h.addr;
            req_wdata[i*DW +: DW] = h.data;
        end
    endtask

    task automatic push_beat(int i, logic we, logic [AW-1:0] a, logic [DW-1:0] d, logic last);
        bq[i].push_back('{we: we, addr: a, data: d, last: last});
        if (we) mdl[int'(a)] = d;
        else exp_q[i].push_back(mdl.exists(int'(a)) ? mdl[int'(a)] : f(a));
        drive();
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            bq[i].delete();
            exp_q[i].delete();
        end
        drive();
    endtask

    task automatic clear_logs();
        glog.delete();
        en_cyc.delete();
        rsp_cyc.delete();
        e.delete();
    endtask

    task automatic sample();
        beat_t h;
        s_busy = busy;
        acc = req_ready;
        if (rsp_valid != 0) begin
            rsp_cyc.push_back(cyc);
            check("rsp_onehot", $countones(rsp_valid), 1);
            for (int i = 0; i < N; i++)
                if (rsp_valid[i]) begin
                    if (exp_q[i].size() == 0) check("rsp_unexpected", rsp_valid, 0);
                    else check("rsp_data", rsp_rdata, exp_q[i].pop_front());
                end
        end
        if (mem_en) begin
            en_cyc.push_back(cyc);
            glog.push_back(int'(grant_id));
            check("ready_onehot", req_ready, 3'b001 << grant_id);
            if (bq[grant_id].size() > 0) begin
                h = bq[grant_id][0];
                check("mem_addr", mem_addr, h.addr);
                check("mem_we", mem_we, h.we);
                if (h.we) check("mem_wdata", mem_wdata, h.data);
            end
        end else check("ready_idle", req_ready, 0);
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i] && bq[i].size() > 0) void'(bq[i].pop_front());
        drive();
    endtask

    function automatic int pending();
        int p = 0;
        for (int i = 0; i < N; i++) p += bq[i].size() + exp_q[i].size();
        return p;
    endfunction

    task automatic run(string tag, int limit);
        int n = 0;
        while (pending() > 0 && n < limit) begin
            step();
            n++;
        end
        check({tag, "_drain"}, pending(), 0);
    endtask

    task automatic check_seq(string tag);
        check({tag, "_len"}, glog.size(), e.size());
        for (int k = 0; k < e.size() && k < glog.size(); k++) check({tag, "_order"}, glog[k], e[k]);
        if (en_cyc.size() > 0)
            check({tag, "_contig"}, en_cyc[en_cyc.size()-1] - en_cyc[0], en_cyc.size() - 1);
    endtask

    task automatic check_quiet(string tag);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_mem_en"}, mem_en, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_grant"}, grant_id, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        rst = 1'b1;
        flush();
        #1;
        check_quiet("reset");
        do_reset();

        // T1: single requester 4-beat read burst
        for (int k = 0; k < 4; k++) push_beat(REQ_SIGMA, 1'b0, 19'h100 + 19'(k), '0, k == 3);
        run("t1", 40);
        for (int k = 0; k < 4; k++) e.push_back(REQ_SIGMA);
        check_seq("t1");
        check("t1_rsp_cnt", rsp_cyc.size(), 4);
        for (int k = 0; k < 4 && k < rsp_cyc.size() && k < en_cyc.size(); k++)
            check("t1_rsp_lat", rsp_cyc[k] - en_cyc[k], 1);
        check("t1_busy_after", s_busy, 0);

        // T2: all three request continuously with 2-beat bursts
        do_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 4; k++) push_beat(i, 1'b0, 19'h200 + 19'(i*16 + k), '0, k % 2 == 1);
        run("t2", 60);
`ifdef FRAME_MEM_ARB_PRIO_EN
        e = '{0, 0, 0, 0, 1, 1, 2, 2, 1, 1, 2, 2};
`else
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) begin
                e.push_back(i);
                e.push_back(i);
            end
`endif
        check_seq("t2");

        // T3: 20-beat burst without req_last is cut at MAX_BURST
        do_reset();
        for (int k = 0; k < 20; k++) push_beat(REQ_MEM_MGR, 1'b0, 19'h300 + 19'(k), '0, k == 19);
`ifndef FRAME_MEM_ARB_PRIO_EN
        repeat (5) step();
        push_beat(REQ_FRAME_MGR, 1'b0, 19'h500, '0, 1'b0);
        push_beat(REQ_FRAME_MGR, 1'b0, 19'h501, '0, 1'b1);
`endif
        run("t3", 80);
        for (int k = 0; k < 16; k++) e.push_back(REQ_MEM_MGR);
`ifndef FRAME_MEM_ARB_PRIO_EN
        e.push_back(REQ_FRAME_MGR);
        e.push_back(REQ_FRAME_MGR);
`endif
        for (int k = 0; k < 4; k++) e.push_back(REQ_MEM_MGR);
        check_seq("t3");

        // T4: write then read of the same address on consecutive beats
        do_reset();
        push_beat(REQ_FRAME_MGR, 1'b1, 19'h10, 16'hBEEF, 1'b1);
        step();
        push_beat(REQ_SIGMA, 1'b0, 19'h10, '0, 1'b1);
        run("t4", 20);
        e = '{0, 1};
        check_seq("t4");
        check("t4_rsp_cnt", rsp_cyc.size(), 1);

`ifdef FRAME_MEM_ARB_PRIO_EN
        // T5: requester 0 preempts an 8-beat burst at beat 3
        do_reset();
        for (int k = 0; k < 8; k++) push_beat(REQ_SIGMA, 1'b0, 19'h600 + 19'(k), '0, k == 7);
        repeat (2) step();
        push_beat(REQ_FRAME_MGR, 1'b1, 19'h400, 16'h1234, 1'b1);
        run("t5", 40);
        e = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
        check_seq("t5");
`endif

        // T6: reset pulsed mid read burst
        do_reset();
        for (int k = 0; k < 6; k++) push_beat(REQ_SIGMA, 1'b0, 19'h700 + 19'(k), '0, k == 5);
        repeat (2) step();
        rst = 1'b1;
        #1;
        check_quiet("t6_in_reset");
        flush();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        repeat (4) step();
        check("t6_no_rsp", rsp_cyc.size(), 0);
        check("t6_no_beat", en_cyc.size(), 0);
        check("t6_busy", s_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
